usb_line_framer: RTL and testbench

- Upstream neighbour of the FT232H bridge.
- Takes one scanner line as an 8-bit valid/ready stream and wraps it in a frame: header, payload, then checksum.
- Acts as an Avalon-MM master on the bridge's byte-wide slave. It reads the bridge's TX status registers to obtain write credits, then writes frame bytes to the WRDATA register.
- The bridge has no waitrequest, so the framer never writes more bytes than the credit it has read back.

---
 rtl/usb_frame_pkg.sv | 17 +
 rtl/usb_credit_poller.sv | 93 +++++++++
 rtl/usb_line_framer.sv | 149 ++++++++++++++
 tb/tb_usb_line_framer.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_frame_pkg.sv
// Shared constants and state encoding for the USB line framer and its credit poller.
package usb_frame_pkg;

  localparam logic [7:0] Sync0 = 8'hA5;
  localparam logic [7:0] Sync1 = 8'h5A;

  localparam logic [3:0] AddrWrdata    = 4'd0;
  localparam logic [3:0] AddrTxStatusL = 4'd2;
  localparam logic [3:0] AddrTxStatusH = 4'd3;

  localparam int unsigned HdrLen = 6;

  typedef enum logic [2:0] {
    StIdle, StRdL, StWtL, StRdH, StWtH, StCalc, StSend, StDone
  } state_e;

endpackage

// File: rtl/usb_credit_poller.sv
// Reads the bridge TXSTATUS low/high bytes and turns them into a write credit.
module usb_credit_poller #(
  parameter int unsigned TX_FIFO_DEPTH  = 512,
  parameter int unsigned TX_FIFO_WIDTHU = 9,
  parameter int unsigned SAFETY_MARGIN  = 8,
  parameter int unsigned READ_LATENCY   = 3
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      start_i,
  input  logic [7:0]                m_readdata_i,
  output logic                      m_read_o,
  output logic [3:0]                m_address_o,
  output logic [TX_FIFO_WIDTHU:0]   credit_o,
  output logic                      credit_valid_o
);
  import usb_frame_pkg::*;

  localparam int unsigned CW = TX_FIFO_WIDTHU + 1;

  state_e     r_state;
  logic [7:0] r_cnt;
  logic [7:0] r_lo;
  logic [7:0] r_hi;

  logic [15:0]   w_status;
  logic          w_full;
  logic [CW-1:0] w_used;
  logic [CW-1:0] w_free;
  logic [CW-1:0] w_credit;
  logic          w_unused_status;

  assign w_status        = {r_hi, r_lo};
  assign w_full          = w_status[TX_FIFO_WIDTHU];
  assign w_used          = w_full ? '0 : {1'b0, w_status[TX_FIFO_WIDTHU-1:0]};
  assign w_free          = CW'(TX_FIFO_DEPTH) - w_used;
  // Margin absorbs wrusedw synchroniser lag inside the bridge.
  assign w_credit        = (w_full || (w_free <= CW'(SAFETY_MARGIN))) ? '0
                                                                     : w_free - CW'(SAFETY_MARGIN);
  assign w_unused_status = ^w_status[15:TX_FIFO_WIDTHU+1];

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state        <= StIdle;
      r_cnt          <= '0;
      r_lo           <= '0;
      r_hi           <= '0;
      m_read_o       <= 1'b0;
      m_address_o    <= '0;
      credit_o       <= '0;
      credit_valid_o <= 1'b0;
    end else begin
      m_read_o       <= 1'b0;
      credit_valid_o <= 1'b0;
      case (r_state)
        StIdle: if (start_i) begin
          r_state     <= StRdL;
          m_read_o    <= 1'b1;
          m_address_o <= AddrTxStatusL;
        end
        StRdL: begin
          r_state <= StWtL;
          r_cnt   <= '0;
        end
        StWtL: if (r_cnt == 8'(READ_LATENCY - 1)) begin
          r_lo        <= m_readdata_i;
          r_state     <= StRdH;
          m_read_o    <= 1'b1;
          m_address_o <= AddrTxStatusH;
        end else begin
          r_cnt <= r_cnt + 8'd1;
        end
        StRdH: begin
          r_state <= StWtH;
          r_cnt   <= '0;
        end
        StWtH: if (r_cnt == 8'(READ_LATENCY - 1)) begin
          r_hi    <= m_readdata_i;
          r_state <= StCalc;
        end else begin
          r_cnt <= r_cnt + 8'd1;
        end
        StCalc: begin
          credit_o       <= w_credit;
          credit_valid_o <= 1'b1;
          r_state        <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

endmodule

// File: rtl/usb_line_framer.sv
// Wraps one scanner line in a sync/header/payload/checksum frame and writes it to the bridge.
module usb_line_framer #(
  parameter int unsigned TX_FIFO_DEPTH  = 512,
  parameter int unsigned TX_FIFO_WIDTHU = 9,
  parameter int unsigned SAFETY_MARGIN  = 8,
  parameter int unsigned READ_LATENCY   = 3
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        start_i,
  input  logic [15:0] line_num_i,
  input  logic [15:0] len_i,
  input  logic [7:0]  s_data_i,
  input  logic        s_valid_i,
  output logic        s_ready_o,
  output logic [3:0]  m_address_o,
  output logic        m_read_o,
  input  logic [7:0]  m_readdata_i,
  output logic        m_write_o,
  output logic [7:0]  m_writedata_o,
  output logic        busy_o,
  output logic        done_o
);
  import usb_frame_pkg::*;

  localparam int unsigned CW = TX_FIFO_WIDTHU + 1;

  state_e        r_state;
  logic [15:0]   r_line;
  logic [15:0]   r_len;
  logic [16:0]   r_idx;
  logic [7:0]    r_chk;
  logic [CW-1:0] r_credit;
  logic          r_poll_start;
  logic [3:0]    r_addr_last;

  logic          w_poll_rd;
  logic [3:0]    w_poll_addr;
  logic [CW-1:0] w_poll_credit;
  logic          w_poll_valid;
  logic [16:0]   w_chk_idx;
  logic          w_in_payload;
  logic          w_is_chk;
  logic          w_can_send;
  logic          w_write;
  logic [7:0]    w_byte;

  usb_credit_poller #(
    .TX_FIFO_DEPTH  (TX_FIFO_DEPTH),
    .TX_FIFO_WIDTHU (TX_FIFO_WIDTHU),
    .SAFETY_MARGIN  (SAFETY_MARGIN),
    .READ_LATENCY   (READ_LATENCY)
  ) u_poller (
    .clk_i          (clk_i),
    .reset_i        (reset_i),
    .start_i        (r_poll_start),
    .m_readdata_i   (m_readdata_i),
    .m_read_o       (w_poll_rd),
    .m_address_o    (w_poll_addr),
    .credit_o       (w_poll_credit),
    .credit_valid_o (w_poll_valid)
  );

  assign w_chk_idx    = {1'b0, r_len} + 17'(HdrLen);
  assign w_in_payload = (r_idx >= 17'(HdrLen)) && (r_idx < w_chk_idx);
  assign w_is_chk     = (r_idx == w_chk_idx);
  assign w_can_send   = (r_state == StSend) && (r_credit != '0);
  assign s_ready_o    = w_can_send && w_in_payload;
  // Payload bytes go out on the handshake cycle itself; header/CHK need no handshake.
  assign w_write      = w_can_send && (w_in_payload ? s_valid_i : 1'b1);

  always_comb begin
    w_byte = r_chk;
    if (r_idx < 17'(HdrLen)) begin
      case (r_idx[2:0])
        3'd0:    w_byte = Sync0;
        3'd1:    w_byte = Sync1;
        3'd2:    w_byte = r_line[15:8];
        3'd3:    w_byte = r_line[7:0];
        3'd4:    w_byte = r_len[15:8];
        default: w_byte = r_len[7:0];
      endcase
    end else if (w_in_payload) begin
      w_byte = s_data_i;
    end
  end

  assign m_read_o      = w_poll_rd;
  assign m_write_o     = w_write;
  assign m_writedata_o = w_write ? w_byte : 8'h00;
  assign m_address_o   = w_poll_rd ? w_poll_addr : (w_write ? AddrWrdata : r_addr_last);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state      <= StIdle;
      r_line       <= '0;
      r_len        <= '0;
      r_idx        <= '0;
      r_chk        <= '0;
      r_credit     <= '0;
      r_poll_start <= 1'b0;
      r_addr_last  <= '0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
    end else begin
      r_poll_start <= 1'b0;
      r_addr_last  <= m_address_o;
      case (r_state)
        StIdle: if (start_i) begin
          r_line       <= line_num_i;
          r_len        <= len_i;
          r_idx        <= '0;
          r_chk        <= '0;
          busy_o       <= 1'b1;
          r_poll_start <= 1'b1;
          r_state      <= StRdL;
        end
        // The poller sequences RD_L..CALC; the framer just waits for its verdict.
        StRdL: if (w_poll_valid) begin
          if (w_poll_credit == '0) begin
            r_poll_start <= 1'b1;
          end else begin
            r_credit <= w_poll_credit;
            r_state  <= StSend;
          end
        end
        StSend: if (w_write) begin
          r_idx    <= r_idx + 17'd1;
          r_credit <= r_credit - CW'(1);
          if (w_in_payload) r_chk <= r_chk + s_data_i;
          if (w_is_chk) begin
            r_state <= StDone;
            done_o  <= 1'b1;
          end else if (r_credit == CW'(1)) begin
            r_state      <= StRdL;
            r_poll_start <= 1'b1;
          end
        end
        StDone: begin
          done_o  <= 1'b0;
          busy_o  <= 1'b0;
          r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_usb_line_framer.sv
// Directed bench for usb_line_framer with a byte-wide bridge status model and payload source.
module tb_usb_line_framer;

  logic        clk = 1'b0;
  logic        reset_i = 1'b1;
  logic        start_i = 1'b0;
  logic [15:0] line_num_i = '0;
  logic [15:0] len_i = '0;
  logic [7:0]  s_data_i = '0;
  logic        s_valid_i = 1'b0;
  logic        s_ready_o;
  logic [3:0]  m_address_o;
  logic        m_read_o;
  logic [7:0]  m_readdata_i = 8'hEE;
  logic        m_write_o;
  logic [7:0]  m_writedata_o;
  logic        busy_o;
  logic        done_o;

  usb_line_framer dut (
    .clk_i         (clk),
    .reset_i       (reset_i),
    .start_i       (start_i),
    .line_num_i    (line_num_i),
    .len_i         (len_i),
    .s_data_i      (s_data_i),
    .s_valid_i     (s_valid_i),
    .s_ready_o     (s_ready_o),
    .m_address_o   (m_address_o),
    .m_read_o      (m_read_o),
    .m_readdata_i  (m_readdata_i),
    .m_write_o     (m_write_o),
    .m_writedata_o (m_writedata_o),
    .busy_o        (busy_o),
    .done_o        (done_o)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Bridge / source model state
  logic [8:0] tb_used = 9'd0;
  logic       tb_full = 1'b0;
  bit         pl_rand = 1'b0;
  logic [7:0] pl_q[$];
  logic [7:0] wr_q[$];
  logic [7:0] exp_q[$];
  int         poll_wr[$];
  logic       rd_v[4] = '{default: 1'b0};
  logic [3:0] rd_a[4] = '{default: 4'd0};
  int reads = 0, done_cnt = 0, overlap = 0, viol = 0, badaddr = 0;
  int avail = 0, since = 0;
  logic [7:0] lo_ret = '0;

  // Read data appears READ_LATENCY=3 cycles after the strobe cycle; junk otherwise.
  always @(posedge clk) begin
    logic [15:0] st;
    #1;
    for (int i = 3; i > 0; i--) begin
      rd_v[i] = rd_v[i-1];
      rd_a[i] = rd_a[i-1];
    end
    rd_v[0] = m_read_o;
    rd_a[0] = m_address_o;
    st = tb_full ? 16'h0200 : {1'b1, 6'b0, tb_used};
    if (rd_v[3] && rd_a[3] == 4'd2)      m_readdata_i = st[7:0];
    else if (rd_v[3] && rd_a[3] == 4'd3) m_readdata_i = st[15:8];
    else                                 m_readdata_i = 8'hEE;
    s_valid_i = (pl_q.size() != 0) && (!pl_rand || ($urandom_range(0, 1) == 1));
    s_data_i  = (pl_q.size() != 0) ? pl_q[0] : 8'h00;
  end

  always @(negedge clk) begin
    int used_m;
    if (m_read_o && m_write_o) overlap++;
    if (m_read_o) begin
      reads++;
      if (m_address_o == 4'd2) poll_wr.push_back(wr_q.size());
      else if (m_address_o != 4'd3) badaddr++;
    end
    if (rd_v[3]) begin
      if (rd_a[3] == 4'd3) begin
        used_m = int'({m_readdata_i[0], lo_ret});
        if (m_readdata_i[1])    avail = 0;
        else if (512 - used_m > 8) avail = 512 - used_m - 8;
        else                    avail = 0;
        since = 0;
      end else begin
        lo_ret = m_readdata_i;
      end
    end
    if (m_write_o) begin
      if (m_address_o != 4'd0) badaddr++;
      if (since >= avail) viol++;
      since++;
      wr_q.push_back(m_writedata_o);
    end
    if (s_valid_i && s_ready_o) void'(pl_q.pop_front());
    if (done_o) done_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clear_counts();
    wr_q.delete();
    poll_wr.delete();
    reads = 0;
    done_cnt = 0;
  endtask

  task automatic start_frame(input logic [15:0] line, input logic [15:0] len);
    @(posedge clk); #2;
    start_i = 1'b1; line_num_i = line; len_i = len;
    @(posedge clk); #2;
    start_i = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    logic got = 1'b0;
    while (n < budget && !got) begin
      @(negedge clk);
      if (done_o) got = 1'b1;
      n++;
    end
    chk({tag, "_done_seen"}, got, 1'b1);
    chk({tag, "_busy_in_done"}, busy_o, 1'b1);
    @(negedge clk);
    chk({tag, "_busy_after"}, busy_o, 1'b0);
    chk({tag, "_done_once"}, done_cnt, 1);
  endtask

  task automatic check_frame(input string tag);
    int nbad = 0;
    int first = -1;
    chk({tag, "_len"}, wr_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++)
      if (wr_q[i] !== exp_q[i]) begin
        nbad++;
        if (first < 0) first = i;
      end
    chk({tag, "_bytes_bad_first_idx"}, (nbad == 0) ? -1 : first, -1);
  endtask

  initial begin
    logic [7:0] sum;
    logic [7:0] b;
    int n;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_done", done_o, 1'b0);
    chk("rst_read", m_read_o, 1'b0);
    chk("rst_write", m_write_o, 1'b0);
    chk("rst_ready", s_ready_o, 1'b0);
    chk("rst_addr", m_address_o, 4'd0);
    chk("rst_wdata", m_writedata_o, 8'h00);
    @(posedge clk); #2;
    reset_i = 1'b0;

    // Empty FIFO, short frame
    clear_counts();
    tb_used = 9'd0;
    pl_q = '{8'h01, 8'h02, 8'h03, 8'h04};
    start_frame(16'h0102, 16'd4);
    wait_done("t1", 200);
    exp_q = '{8'hA5, 8'h5A, 8'h01, 8'h02, 8'h00, 8'h04, 8'h01, 8'h02, 8'h03, 8'h04, 8'h0A};
    check_frame("t1");
    chk("t1_reads", reads, 2);

    // Zero-length payload
    clear_counts();
    start_frame(16'hFFFF, 16'd0);
    wait_done("t2", 200);
    exp_q = '{8'hA5, 8'h5A, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00};
    check_frame("t2");

    // Free space below the margin until the FIFO drains
    clear_counts();
    tb_used = 9'd505;
    pl_q = '{8'h10, 8'h20, 8'h30};
    start_frame(16'h0003, 16'd3);
    repeat (20) @(negedge clk);
    chk("t3_no_writes", wr_q.size(), 0);
    chk("t3_repolled", reads > 2, 1'b1);
    tb_used = 9'd0;
    wait_done("t3", 400);
    exp_q = '{8'hA5, 8'h5A, 8'h00, 8'h03, 8'h00, 8'h03, 8'h10, 8'h20, 8'h30, 8'h60};
    check_frame("t3");

    // Full flag blocks everything
    clear_counts();
    tb_full = 1'b1;
    pl_q = '{8'hF0, 8'h20};
    start_frame(16'h1234, 16'd2);
    repeat (60) @(negedge clk);
    chk("t4_no_writes", wr_q.size(), 0);
    chk("t4_polling", reads >= 4, 1'b1);
    tb_full = 1'b0;
    wait_done("t4", 400);
    exp_q = '{8'hA5, 8'h5A, 8'h12, 8'h34, 8'h00, 8'h02, 8'hF0, 8'h20, 8'h10};
    check_frame("t4");

    // Long frame: credit exhaustion mid-payload, randomly gapped source
    clear_counts();
    pl_rand = 1'b1;
    exp_q = '{8'hA5, 8'h5A, 8'h00, 8'h07, 8'h02, 8'h58};
    sum = 8'h00;
    for (int i = 0; i < 600; i++) begin
      b = 8'($urandom);
      pl_q.push_back(b);
      exp_q.push_back(b);
      sum = sum + b;
    end
    exp_q.push_back(sum);
    start_frame(16'h0007, 16'd600);
    wait_done("t5", 5000);
    check_frame("t5");
    chk("t5_polls", poll_wr.size(), 2);
    chk("t5_first_burst", (poll_wr.size() > 1) ? poll_wr[1] : -1, 504);
    pl_rand = 1'b0;

    // Reset in the middle of the payload
    clear_counts();
    for (int i = 0; i < 10; i++) pl_q.push_back(8'(i + 1));
    start_frame(16'h0A0B, 16'd10);
    n = 0;
    while (n < 300 && wr_q.size() < 8) begin
      @(negedge clk);
      n++;
    end
    chk("t6_reached_payload", wr_q.size() >= 8, 1'b1);
    @(posedge clk); #2;
    reset_i = 1'b1;
    pl_q.delete();
    @(posedge clk); #2;
    reset_i = 1'b0;
    @(negedge clk);
    chk("t6_busy", busy_o, 1'b0);
    chk("t6_write", m_write_o, 1'b0);
    chk("t6_read", m_read_o, 1'b0);
    chk("t6_ready", s_ready_o, 1'b0);
    chk("t6_addr", m_address_o, 4'd0);
    chk("t6_wdata", m_writedata_o, 8'h00);
    clear_counts();
    pl_q = '{8'hAA, 8'hBB};
    start_frame(16'h0A0B, 16'd2);
    wait_done("t6", 200);
    exp_q = '{8'hA5, 8'h5A, 8'h0A, 8'h0B, 8'h00, 8'h02, 8'hAA, 8'hBB, 8'h65};
    check_frame("t6");

    chk("no_rd_wr_overlap", overlap, 0);
    chk("no_write_past_credit", viol, 0);
    chk("bus_addresses", badaddr, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
